// File: rtl/nor_reduce_pipe.sv
// Pipelined WIDTH-input reduction gate (NOR/OR/AND/NAND/XOR/XNOR) built from
// registered FANIN-input tree nodes, with a valid chain and clock enable.

module nor_reduce_node #(
    parameter int FANIN = 4,
    parameter int OP    = 0
) (
    input  logic [FANIN-1:0] x,
    output logic             y
);
    always_comb begin
        if (OP == 1)      y = &x;
        else if (OP == 2) y = ^x;
        else              y = |x;
    end
endmodule

module nor_reduce_pipe #(
    parameter int WIDTH = 6,
    parameter int FANIN = 4,
    parameter int MODE  = 0
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic             VI,
    input  logic [WIDTH-1:0] A,
    output logic             ZN0,
    output logic             VO
);
    localparam int FI = (FANIN < 2) ? 2 : FANIN;

    function automatic int nodes_at(input int s);
        int n;
        n = WIDTH;
        for (int i = 0; i < s; i++) n = (n + FI - 1) / FI;
        return n;
    endfunction

    function automatic int calc_stages();
        int s;
        s = 1;
        for (int i = 0; i < 40; i++) if (nodes_at(s) > 1) s++;
        return s;
    endfunction

    function automatic int node_off(input int s);
        int o;
        o = 0;
        for (int i = 1; i < s; i++) o += nodes_at(i);
        return o;
    endfunction

    localparam int   STAGES = calc_stages();
    localparam int   TOT    = node_off(STAGES + 1);
    localparam int   OP     = (MODE == 2 || MODE == 3) ? 1 : (MODE == 4 || MODE == 5) ? 2 : 0;
    localparam logic PAD    = (OP == 1);
    localparam logic INV    = (MODE == 0 || MODE == 3 || MODE == 5);

    if (WIDTH < 1 || FANIN < 2 || FANIN > 8 || MODE < 0 || MODE > 5) begin : g_bad_param
        $error("nor_reduce_pipe: WIDTH/FANIN/MODE out of range");
    end

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES:0]   vld_pipe;

    always_comb begin
        vld_pipe = {vld_q, VI};
        vld_d    = CE ? vld_pipe[STAGES-1:0] : vld_q;
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) vld_q <= '0;
        else    vld_q <= vld_d;
    end

    // All stage registers concatenated; stage s occupies node_off(s) +: nodes_at(s).
    wire [TOT-1:0] tree_q;

    for (genvar s = 1; s <= STAGES; s++) begin : g_stg
        localparam int NI = nodes_at(s - 1);
        localparam int NO = nodes_at(s);

        logic [NI-1:0]       in_w;
        logic [NO*FANIN-1:0] in_pad;
        logic [NO-1:0]       node_y, st_d, st_q;

        if (s == 1) begin : g_in
            assign in_w = A;
        end else begin : g_in
            assign in_w = tree_q[node_off(s-1) +: NI];
        end

        always_comb begin
            in_pad         = {(NO*FANIN){PAD}};
            in_pad[NI-1:0] = in_w;
        end

        for (genvar n = 0; n < NO; n++) begin : g_node
            nor_reduce_node #(.FANIN(FANIN), .OP(OP)) u_node (
                .x (in_pad[n*FANIN +: FANIN]),
                .y (node_y[n])
            );
        end

        if (s == STAGES) begin : g_last
            // Output is forced low when no valid vector lands, so ZN0 is 0
            // after reset and across bubbles, never showing stale tree data.
            always_comb begin
                st_d = st_q;
                if (CE) st_d = (node_y ^ INV) & vld_pipe[STAGES-1];
            end
        end else begin : g_mid
            always_comb begin
                st_d = st_q;
                if (CE) st_d = node_y;
            end
        end

        always_ff @(posedge CK or posedge CD) begin
            if (CD) st_q <= '0;
            else    st_q <= st_d;
        end

        assign tree_q[node_off(s) +: NO] = st_q;
    end

    assign ZN0 = tree_q[TOT-1];
    assign VO  = vld_pipe[STAGES];
endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Drives eight configurations of nor_reduce_pipe from shared stimulus and checks
// each against a per-config delay-line model of the reduction rules.
module tb_nor_reduce_pipe;
    logic       clk = 1'b0;
    logic       cd, ce, vi;
    logic [8:0] a;
    logic [7:0] zn, vo;

    int total = 0;
    int bad   = 0;

    // dut 0: WIDTH=6 FANIN=4 NOR; 1..6: WIDTH=9 FANIN=2 MODE 0..5; 7: WIDTH=1 NAND
    int dw[8] = '{6, 9, 9, 9, 9, 9, 9, 1};
    int dm[8] = '{0, 0, 1, 2, 3, 4, 5, 3};
    int ds[8] = '{2, 4, 4, 4, 4, 4, 4, 1};
    bit mv[8][4];
    bit mz[8][4];

    always #5 clk = ~clk;

    nor_reduce_pipe #(.WIDTH(6), .FANIN(4), .MODE(0)) u_main (
        .CK(clk), .CD(cd), .CE(ce), .VI(vi), .A(a[5:0]), .ZN0(zn[0]), .VO(vo[0]));

    for (genvar m = 0; m < 6; m++) begin : g_m
        nor_reduce_pipe #(.WIDTH(9), .FANIN(2), .MODE(m)) u_dut (
            .CK(clk), .CD(cd), .CE(ce), .VI(vi), .A(a), .ZN0(zn[m+1]), .VO(vo[m+1]));
    end

    nor_reduce_pipe #(.WIDTH(1), .FANIN(2), .MODE(3)) u_w1 (
        .CK(clk), .CD(cd), .CE(ce), .VI(vi), .A(a[0:0]), .ZN0(zn[7]), .VO(vo[7]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_fn(input int mode, input logic [8:0] av, input int w);
        int ones;
        bit r;
        ones = 0;
        for (int i = 0; i < w; i++) ones += int'(av[i]);
        case (mode)
            0, 1:    r = (ones != 0);
            2, 3:    r = (ones == w);
            default: r = (ones % 2 == 1);
        endcase
        if (mode == 0 || mode == 3 || mode == 5) r = !r;
        return r;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 8; d++)
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                mz[d][k] = 1'b0;
            end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 8; d++) begin
            chk($sformatf("%s_vo%0d", tag, d), 32'(vo[d]), 32'(mv[d][ds[d]-1]));
            chk($sformatf("%s_zn%0d", tag, d), 32'(zn[d]),
                32'(mv[d][ds[d]-1] & mz[d][ds[d]-1]));
        end
    endtask

    task automatic step(input bit v, input bit e, input bit r, input logic [8:0] av, input string tag);
        vi = v; ce = e; cd = r; a = av;
        @(posedge clk);
        if (r) clear_model();
        else if (e) begin
            for (int d = 0; d < 8; d++) begin
                for (int k = ds[d] - 1; k > 0; k--) begin
                    mv[d][k] = mv[d][k-1];
                    mz[d][k] = mz[d][k-1];
                end
                mv[d][0] = v;
                mz[d][0] = ref_fn(dm[d], av, dw[d]);
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit exp5[6] = '{0, 1, 1, 0, 1, 0};
        cd = 1'b1; ce = 1'b0; vi = 1'b0; a = '0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_zn", 32'(zn), 32'h0);
        chk("rst_vo", 32'(vo), 32'h0);

        // NOR basics on WIDTH=6
        step(1, 1, 0, 9'h000, "t2");
        step(1, 1, 0, 9'h020, "t2");
        chk("t2_nor_zero", 32'(zn[0]), 32'h1);
        chk("t2_vo", 32'(vo[0]), 32'h1);
        step(0, 1, 0, 9'h000, "t2");
        chk("t2_nor_bit5", 32'(zn[0]), 32'h0);

        // back-to-back walking one, then two zero vectors
        for (int i = 0; i < 10; i++) begin
            step(i < 8, 1, 0, (i < 6) ? 9'(1 << i) : 9'h000, "t3");
            if (i >= 1 && i <= 8) begin
                chk($sformatf("t3_zn_%0d", i - 1), 32'(zn[0]), 32'(i - 1 >= 6));
                chk($sformatf("t3_vo_%0d", i - 1), 32'(vo[0]), 32'h1);
            end
        end

        // CE stall with two vectors in flight
        step(1, 1, 0, 9'h000, "t4");
        step(1, 1, 0, 9'h001, "t4");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 9'($urandom), "t4s");
            chk("t4_hold_zn", 32'(zn[0]), 32'h1);
            chk("t4_hold_vo", 32'(vo[0]), 32'h1);
        end
        step(0, 1, 0, 9'h000, "t4");
        chk("t4_second_zn", 32'(zn[0]), 32'h0);
        chk("t4_second_vo", 32'(vo[0]), 32'h1);
        step(0, 1, 0, 9'h000, "t4");
        chk("t4_drained_vo", 32'(vo[0]), 32'h0);

        // mode sweep, all-ones on WIDTH=9 FANIN=2
        step(1, 1, 0, 9'h1FF, "t5");
        repeat (3) step(0, 1, 0, 9'h000, "t5");
        for (int m = 0; m < 6; m++) begin
            chk($sformatf("t5_mode%0d_zn", m), 32'(zn[m+1]), 32'(exp5[m]));
            chk($sformatf("t5_mode%0d_vo", m), 32'(vo[m+1]), 32'h1);
        end

        // reset mid-stream
        repeat (3) step(1, 1, 0, 9'($urandom), "t1");
        cd = 1'b1;
        #1;
        chk("t1_async_zn", 32'(zn), 32'h0);
        chk("t1_async_vo", 32'(vo), 32'h0);
        clear_model();
        step(1, 1, 1, 9'($urandom), "t1cd");
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 9'($urandom), "t1post");
            chk("t1_post_vo", 32'(vo), 32'h0);
        end

        // randomized traffic
        for (int i = 0; i < 10000; i++)
            step($urandom % 4 != 0, $urandom % 5 != 0, $urandom % 500 == 0,
                 9'($urandom), "rnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
